// File: rtl/change_dispenser.sv
// Coin-return controller: pays a change amount greedily (quarter, dime, nickel)
// from per-denomination tubes, one acknowledged coin at a time.
module change_dispenser #(
    parameter int AMT_W        = 8,
    parameter int TUBE_W       = 6,
    parameter int NICKEL_INIT  = 20,
    parameter int DIME_INIT    = 20,
    parameter int QUARTER_INIT = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             coin_ack,
    input  logic             refill,
    output logic             nickel,
    output logic             dime,
    output logic             quarter,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic             low_change
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam logic [AMT_W-1:0] VAL_N = AMT_W'(5);
    localparam logic [AMT_W-1:0] VAL_D = AMT_W'(10);
    localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(25);

    localparam logic [TUBE_W-1:0] INIT_N = TUBE_W'(NICKEL_INIT);
    localparam logic [TUBE_W-1:0] INIT_D = TUBE_W'(DIME_INIT);
    localparam logic [TUBE_W-1:0] INIT_Q = TUBE_W'(QUARTER_INIT);

    logic [2:0]        r_state;
    logic              r_nickel;
    logic              r_dime;
    logic              r_quarter;
    logic [AMT_W-1:0]  r_remaining;
    logic [TUBE_W-1:0] r_tube_n;
    logic [TUBE_W-1:0] r_tube_d;
    logic [TUBE_W-1:0] r_tube_q;

    logic              w_pick_q;
    logic              w_pick_d;
    logic              w_pick_n;
    logic [AMT_W-1:0]  w_issue_val;

    // A coin qualifies only if it fits in what is owed and its tube is not empty.
    always_comb begin
        w_pick_q = (r_remaining >= VAL_Q) && (r_tube_q != '0);
        w_pick_d = (r_remaining >= VAL_D) && (r_tube_d != '0);
        w_pick_n = (r_remaining >= VAL_N) && (r_tube_n != '0);
    end

    always_comb begin
        w_issue_val = '0;
        if (r_quarter)
            w_issue_val = VAL_Q;
        else if (r_dime)
            w_issue_val = VAL_D;
        else if (r_nickel)
            w_issue_val = VAL_N;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_nickel    <= 1'b0;
            r_dime      <= 1'b0;
            r_quarter   <= 1'b0;
            r_remaining <= '0;
            r_tube_n    <= INIT_N;
            r_tube_d    <= INIT_D;
            r_tube_q    <= INIT_Q;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= amount;
                        r_state     <= S_SELECT;
                    end else if (refill) begin
                        r_tube_n <= INIT_N;
                        r_tube_d <= INIT_D;
                        r_tube_q <= INIT_Q;
                    end
                end
                S_SELECT: begin
                    if (r_remaining == '0) begin
                        r_state <= S_DONE;
                    end else if (w_pick_q) begin
                        r_quarter <= 1'b1;
                        r_state   <= S_ISSUE;
                    end else if (w_pick_d) begin
                        r_dime  <= 1'b1;
                        r_state <= S_ISSUE;
                    end else if (w_pick_n) begin
                        r_nickel <= 1'b1;
                        r_state  <= S_ISSUE;
                    end else begin
                        r_state <= S_FAULT;
                    end
                end
                S_ISSUE: begin
                    if (coin_ack) begin
                        r_nickel    <= 1'b0;
                        r_dime      <= 1'b0;
                        r_quarter   <= 1'b0;
                        r_remaining <= r_remaining - w_issue_val;
                        if (r_quarter)
                            r_tube_q <= r_tube_q - 1'b1;
                        if (r_dime)
                            r_tube_d <= r_tube_d - 1'b1;
                        if (r_nickel)
                            r_tube_n <= r_tube_n - 1'b1;
                        r_state <= S_SELECT;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_FAULT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign nickel     = r_nickel;
    assign dime       = r_dime;
    assign quarter    = r_quarter;
    assign remaining  = r_remaining;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign short      = (r_state == S_FAULT);
    assign low_change = (r_tube_n == '0) || (r_tube_d == '0) || (r_tube_q == '0);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed and randomized checks of change_dispenser against a greedy
// coin-payment model that tracks tube inventories as plain integers.
module tb_change_dispenser;

    localparam int AMT_W = 8;
    localparam int INIT  = 20;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [AMT_W-1:0] amount;
    logic             coin_ack;
    logic             refill;
    logic             nickel;
    logic             dime;
    logic             quarter;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] remaining;
    logic             low_change;

    int n_checks = 0;
    int n_errors = 0;

    // Model inventory, index 0 = quarter, 1 = dime, 2 = nickel.
    int tube[3];
    int coin_val[3] = '{25, 10, 5};

    always #5 clk = ~clk;

    change_dispenser #(
        .AMT_W(AMT_W),
        .TUBE_W(6),
        .NICKEL_INIT(INIT),
        .DIME_INIT(INIT),
        .QUARTER_INIT(INIT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .amount(amount),
        .coin_ack(coin_ack),
        .refill(refill),
        .nickel(nickel),
        .dime(dime),
        .quarter(quarter),
        .busy(busy),
        .done(done),
        .short(short),
        .remaining(remaining),
        .low_change(low_change)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int coins();
        return {29'd0, quarter, dime, nickel};
    endfunction

    function automatic int onehot(input int idx);
        return 4 >> idx;
    endfunction

    function automatic int model_low();
        return (tube[0] == 0 || tube[1] == 0 || tube[2] == 0) ? 1 : 0;
    endfunction

    task automatic model_refill();
        for (int i = 0; i < 3; i++) tube[i] = INIT;
    endtask

    // One full transaction; ack_delay cycles of coin_ack low per coin (0 = tied high).
    // poke raises start and refill during the first wait cycle of each coin.
    task automatic run_txn(input int amt, input int ack_delay, input bit poke);
        int rem;
        int pick;
        rem      = amt;
        start    = 1'b1;
        amount   = AMT_W'(amt);
        coin_ack = (ack_delay == 0);
        tick();
        start  = 1'b0;
        refill = 1'b0;
        check("sel_busy", busy, 1);
        check("sel_rem", remaining, amt);
        check("sel_coins", coins(), 0);
        while (1) begin
            pick = -1;
            for (int i = 0; i < 3; i++)
                if (pick < 0 && rem != 0 && coin_val[i] <= rem && tube[i] > 0) pick = i;
            if (pick < 0) break;
            tick();
            check("issue_coin", coins(), onehot(pick));
            for (int d = 0; d < ack_delay; d++) begin
                if (poke && d == 0) begin
                    start  = 1'b1;
                    refill = 1'b1;
                    amount = 8'd200;
                end
                tick();
                start  = 1'b0;
                refill = 1'b0;
                check("hold_coin", coins(), onehot(pick));
                check("hold_rem", remaining, rem);
            end
            coin_ack = 1'b1;
            tick();
            if (ack_delay != 0) coin_ack = 1'b0;
            rem -= coin_val[pick];
            tube[pick]--;
            check("ack_coins", coins(), 0);
            check("ack_rem", remaining, rem);
            check("ack_low_change", low_change, model_low());
        end
        tick();
        check("end_done", done, (rem == 0));
        check("end_short", short, (rem != 0));
        check("end_rem", remaining, rem);
        check("end_coins", coins(), 0);
        check("end_busy", busy, 1);
        coin_ack = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_short", short, 0);
        check("idle_rem", remaining, rem);
        check("idle_low_change", low_change, model_low());
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        amount   = '0;
        coin_ack = 1'b0;
        refill   = 1'b0;
        model_refill();
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_coins", coins(), 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_short", short, 0);
        check("rst_rem", remaining, 0);
        check("rst_low_change", low_change, 0);

        run_txn(40, 0, 1'b0);
        run_txn(25, 3, 1'b0);
        run_txn(7, 0, 1'b0);
        run_txn(0, 0, 1'b0);
        run_txn(35, 2, 1'b1);

        // Reset while a quarter is being requested aborts silently and refills.
        start    = 1'b1;
        amount   = 8'd40;
        coin_ack = 1'b0;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_quarter", coins(), 4);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        model_refill();
        check("abort_coins", coins(), 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_short", short, 0);
        check("abort_rem", remaining, 0);
        tick();
        check("abort_done2", done, 0);
        check("abort_short2", short, 0);
        check("abort_busy2", busy, 0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                refill = 1'b1;
                tick();
                refill = 1'b0;
                model_refill();
                check("rnd_refill_low", low_change, 0);
            end
            run_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
        end

        // Empty the nickel tube, then exercise the greedy shortfall cases.
        refill = 1'b1;
        tick();
        refill = 1'b0;
        model_refill();
        for (int n = 0; n < INIT; n++) run_txn(5, 0, 1'b0);
        check("drained_low", low_change, 1);
        run_txn(30, 0, 1'b0);
        refill = 1'b1;
        run_txn(5, 0, 1'b0);
        check("start_beats_refill", low_change, 1);
        refill = 1'b1;
        tick();
        refill = 1'b0;
        model_refill();
        check("refill_low", low_change, 0);
        run_txn(30, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
